// File: rtl/ltl_report_collector.sv
// Report-event collector for the LTL automata monitors: stamps each qualified report with its symbol index and queues it.
// Optional rising-edge qualification of the report wires is compiled in with LTL_REPORT_EDGE_DETECT_EN.
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int CNT_W       = 32,
    parameter int DEPTH       = 8,
    parameter int DROP_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     clear,
    input  logic [NUM_REPORTS-1:0]   report,
    input  logic                     irq_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_REPORTS-1:0]   out_report,
    output logic [CNT_W-1:0]         out_stamp,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [CNT_W-1:0]       sym_cnt;
    logic [NUM_REPORTS-1:0] mem_report [DEPTH];
    logic [CNT_W-1:0]       mem_stamp  [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [NUM_REPORTS-1:0] qual;
    logic                   evt;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [LW-1:0]          level_next;
    logic                   overflow_next;

`ifdef LTL_REPORT_EDGE_DETECT_EN
    logic [NUM_REPORTS-1:0] report_q;

    // History only advances on consumed symbols, so idle cycles do not re-arm an edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            report_q <= '0;
        end else if (run) begin
            report_q <= report;
        end
    end

    assign qual = report & ~report_q;
`else
    assign qual = report;
`endif

    assign out_valid     = (level != '0);
    assign full          = (level == LW'(DEPTH));
    assign pop           = out_valid & out_ready;
    assign evt           = run & (|qual);
    assign push          = evt & (~full | pop);
    assign drop          = evt & full & ~pop;
    assign level_next    = clear ? '0 : (level + LW'(push) - LW'(pop));
    assign overflow_next = ~clear & (overflow | drop);

    // Head is read straight from storage; masked while empty so stale entries never show.
    assign out_report = out_valid ? mem_report[rd_ptr] : '0;
    assign out_stamp  = out_valid ? mem_stamp[rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            sym_cnt  <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            level    <= level_next;
            overflow <= overflow_next;
            irq      <= irq_en & ((level_next != '0) | overflow_next);
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                sym_cnt  <= '0;
                drop_cnt <= '0;
            end else begin
                if (run) begin
                    sym_cnt <= sym_cnt + CNT_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (drop && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && push) begin
            mem_report[wr_ptr] <= qual;
            mem_stamp[wr_ptr]  <= sym_cnt;
        end
    end

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Sits directly downstream of the generated LTL automata monitors; consumes their per-cycle report wires (active_state of report STEs).
- Stamps each report event with the index of the symbol that raised it and buffers events in a FIFO.
- Exposes events through a valid/ready interface and a level interrupt to the core-side monitor controller.
- One instance per monitor cluster. Report wires from several automata are concatenated into the report vector.

Parameters:
- NUM_REPORTS, 4, number of report inputs, minimum 1.
- CNT_W, 32, width of the symbol index counter and of the timestamp.
- DEPTH, 8, FIFO entries; must be a power of 2, minimum 2.
- DROP_W, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- run  in  1  same run strobe fed to the monitors; high means a symbol is consumed this cycle.
- clear  in  1  synchronous flush: empties the FIFO, zeroes sym_cnt, overflow and drop_cnt.
- report  in  NUM_REPORTS  report wires from the monitor(s).
- irq_en  in  1  interrupt enable.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_report  out  NUM_REPORTS  report vector of the head entry.
- out_stamp  out  CNT_W  symbol index of the head entry.
- overflow  out  1  sticky; set when an event was dropped.
- drop_cnt  out  DROP_W  saturating count of dropped events.
- level  out  clog2(DEPTH)+1  current FIFO occupancy.
- irq  out  1  registered interrupt.

Behaviour:
- Reset: all outputs, FIFO pointers, sym_cnt, overflow, drop_cnt and irq are 0; out_report and out_stamp are 0.
- sym_cnt:
  - Increments by 1 at the end of every cycle with run=1; holds when run=0.
  - Wraps modulo 2^CNT_W silently.
- Event qualification:
  - In a cycle with run=1, an event exists when the qualified report vector is non-zero; run=0 produces no event.
  - The qualified vector is either report or its rising edges (see Optional Feature).
- Push: the entry {qualified vector, sym_cnt value in that cycle} is written.
- Occupancy and visibility:
  - Write takes effect on the next posedge.
  - out_valid rises one cycle after the push; first-word latency is 1.
  - Head outputs are driven from FIFO storage (show-ahead). out_report and out_stamp are stable while out_valid=1 and out_ready=0.
- Pop: occurs when out_valid && out_ready.
- Simultaneous push and pop:
  - Allowed at any level, including full: both happen and level is unchanged.
  - When empty, push only; the entry is not bypassed.
- Full with push and no pop:
  - The entry is dropped and overflow is set (sticky).
  - drop_cnt increments, saturating at 2^DROP_W-1.
  - Stored entries are untouched.
- Clear:
  - Has priority over push and pop in the same cycle. That cycle's event is discarded and is not counted as a drop.
  - Next cycle: level=0, out_valid=0, sym_cnt=0, overflow=0, drop_cnt=0.
- irq:
  - Registered: irq <= irq_en && (next level != 0 || next overflow).
  - Follows out_valid with the same 1-cycle timing.
- Reset mid-operation: returns everything to the reset state on the next posedge. No entry survives and no pop is acknowledged.
- The edge-detect history register (when compiled in) is also cleared by reset and clear.

Optional Feature:
- Macro: LTL_REPORT_EDGE_DETECT_EN.
- Defined:
  - Qualified vector = report & ~report_q.
  - report_q updates to report only in run=1 cycles.
  - A report held high across consecutive symbols is logged once, at the first symbol.
- Undefined: qualified vector = report. Every symbol with any active report produces an entry. No report_q register exists.

Test Plan:
- Basic stamp: reset, run=1 continuously, report=4'b0100 only in the cycle where sym_cnt=5, out_ready=1 → one entry {0100, 5}; out_valid high for exactly 1 cycle, 1 cycle after the report.
- run gating: report=4'b0001 held while run=0 for 3 cycles, then run=1 at sym_cnt=0 → exactly one entry {0001, 0}; irq=1 with irq_en=1.
- Overflow: DEPTH=8, out_ready=0, 11 consecutive events with distinct reports → level=8, overflow=1, drop_cnt=3. Draining yields stamps 0..7 in order; then out_valid=0 and irq stays 1 until clear.
- Full push+pop: fill to 8, then one cycle with event and out_ready=1 → level stays 8, overflow=0, and the new entry is last in the drain order.
- Clear priority: level=3, clear=1 with a simultaneous event and out_ready=1 → next cycle level=0, sym_cnt=0, drop_cnt=0, no entry.
- Edge detect (macro defined): report=4'b0010 held for 4 run cycles starting at sym_cnt=2 → one entry {0010, 2}. With the macro undefined → 4 entries with stamps 2, 3, 4, 5.
